conv_bram_sr_fast_reader: RTL and testbench
===========================================

Name: conv_bram_sr_fast_reader

Overview:
Read-side sequencer for the fast shift-register 2D convolution datapath. It walks the source image column by column across one FILTER_L-row window at a time. Each cycle it issues FILTER_L parallel BRAM read addresses (one per row bank, shared by all IMG_D channels). It delays the datapath controls (wren, rotation offset, result write address) to line up with the returned BRAM data. It owns the start/done handshake for one full convolution pass and waits for the datapath's last_val before reporting done.

Parameters:
DATA_WIDTH, 12, pixel width (informational; no data passes through this block)
IMG_W, 16, image width
IMG_H, 16, image height
IMG_D, 32, image depth (informational)
FILTER_L, 3, square filter side; also the number of row banks
RD_LATENCY, 1, BRAM read latency in cycles (>=1)
RESULT_W, (IMG_W-FILTER_L)+1, derived; stride fixed at 1
RESULT_H, (IMG_H-FILTER_L)+1, derived
IMG_RAM_ADDR_WIDTH, $clog2(IMG_W*IMG_H), derived
FILTER_L_ADDR_WIDTH, $clog2(FILTER_L), derived
RESULT_RAM_ADDR_WIDTH, $clog2(RESULT_W*RESULT_H), derived

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request to begin a pass; sampled only in IDLE
busy  out  1  high from start acceptance until done
done  out  1  one-cycle pulse when the pass completes
img_rden  out  1  read enable to all image banks
img_rdaddr  out  FILTER_L*IMG_RAM_ADDR_WIDTH  bank j address at [j*AW +: AW]
dpath_wren  out  1  shift-enable to datapath, aligned with returned BRAM data
dpath_rotation_offset  out  FILTER_L_ADDR_WIDTH  rotation of bank data into row order
dpath_result_wraddr  out  RESULT_RAM_ADDR_WIDTH  result address tagged to this shift
last_val  in  1  from datapath: final result written

Behaviour:
- One clock, clk. reset is asynchronous and active-low (low = in reset).
- Reset values: state IDLE, all counters 0, busy=0, done=0, img_rden=0, img_rdaddr=0, dpath_wren=0, dpath_rotation_offset=0, dpath_result_wraddr=0, delay pipeline cleared.
- Counters:
  - col in 0..IMG_W-1.
  - top in 0..RESULT_H-1.
  - rot = top mod FILTER_L, kept as a wrapping counter (no divider).
- States:
  - IDLE: start=1 -> ISSUE, col=top=rot=0, busy=1. start is ignored in every other state.
  - ISSUE: img_rden=1 every cycle.
    - Bank j reads row r = top + ((j - rot) mod FILTER_L); img_rdaddr[j] = col + r*IMG_W.
    - col wraps at IMG_W-1 -> 0; on wrap, top++ and rot++ (rot wraps at FILTER_L-1).
    - After the issue with col=IMG_W-1 and top=RESULT_H-1 -> DRAIN. Total issue cycles = RESULT_H*IMG_W.
  - DRAIN: img_rden=0. Wait for last_val=1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Tagged result address per issue:
  - top*RESULT_W when col < FILTER_L-1 (priming shifts; garbage later overwritten in order).
  - otherwise (col-(FILTER_L-1)) + top*RESULT_W.
- Alignment: img_rden, rot and the tagged address pass through an RD_LATENCY-stage register pipeline and appear as dpath_wren, dpath_rotation_offset and dpath_result_wraddr. dpath_wren is high exactly RD_LATENCY cycles after each img_rden.
- The pipeline keeps shifting in DRAIN, DONE and IDLE, so in-flight reads always complete.
- last_val arriving outside DRAIN is ignored.
- Reset asserted mid-pass: immediate return to reset values; in-flight pipeline contents discarded.

Optional Feature:
CONV_READER_STALL_EN:
- Defined: adds input stall (1 bit).
  - While stall=1 in ISSUE: counters hold and img_rden=0. A hole enters the delay pipeline, so dpath_wren=0 RD_LATENCY cycles later.
  - Issue resumes at the same col/top when stall=0.
  - stall has no effect in other states.
- Undefined: no stall port; ISSUE never pauses.

Test Plan:
1. FILTER_L=3, IMG_W=IMG_H=5, start pulse -> img_rden high exactly 15 consecutive cycles. First issue addrs {0,5,10}, offset 0. dpath_wren first high 1 cycle later (RD_LATENCY=1).
2. Same config, top=1 col=0 -> bank0 addr 15, bank1 addr 5, bank2 addr 10, rotation 1. Top=2 col=4 -> addrs {19,24,14}, rotation 2.
3. Tagged wraddr sequence for top=0 -> 0,0,0,1,2. Top=2 -> 6,6,6,7,8. Final dpath_result_wraddr=8.
4. Hold last_val=0 for 10 cycles after issue ends -> busy stays 1, done stays 0. last_val=1 -> done pulses 1 cycle later, busy=0. Start during busy is ignored.
5. Assert reset low in ISSUE at top=1 col=2 -> all outputs 0 immediately. A new start restarts from addrs {0,5,10}.
6. CONV_READER_STALL_EN defined, stall high 3 cycles at col=2 -> img_rden low 3 cycles, col stays 2. dpath_wren has a matching 3-cycle gap. Total img_rden-high cycles still 15.

Source files
------------

// File: rtl/conv_bram_sr_fast_reader_if.sv
// Handshake and BRAM/datapath control bundle for conv_bram_sr_fast_reader.
// The stall input exists only when CONV_READER_STALL_EN is defined.
interface conv_bram_sr_fast_reader_if #(
   parameter int IMG_W    = 16,
   parameter int IMG_H    = 16,
   parameter int FILTER_L = 3
);
   localparam int RESULT_W              = (IMG_W - FILTER_L) + 1;
   localparam int RESULT_H              = (IMG_H - FILTER_L) + 1;
   localparam int IMG_RAM_ADDR_WIDTH    = $clog2(IMG_W * IMG_H);
   localparam int FILTER_L_ADDR_WIDTH   = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
   localparam int RESULT_RAM_ADDR_WIDTH = (RESULT_W * RESULT_H > 1) ? $clog2(RESULT_W * RESULT_H) : 1;

   logic                                     start;
   logic                                     busy;
   logic                                     done;
   logic                                     img_rden;
   logic [FILTER_L*IMG_RAM_ADDR_WIDTH-1:0]   img_rdaddr;
   logic                                     dpath_wren;
   logic [FILTER_L_ADDR_WIDTH-1:0]           dpath_rotation_offset;
   logic [RESULT_RAM_ADDR_WIDTH-1:0]         dpath_result_wraddr;
   logic                                     last_val;
`ifdef CONV_READER_STALL_EN
   logic                                     stall;

   modport master (
      input  start, last_val, stall,
      output busy, done, img_rden, img_rdaddr,
             dpath_wren, dpath_rotation_offset, dpath_result_wraddr
   );

   modport slave (
      output start, last_val, stall,
      input  busy, done, img_rden, img_rdaddr,
             dpath_wren, dpath_rotation_offset, dpath_result_wraddr
   );
`else
   modport master (
      input  start, last_val,
      output busy, done, img_rden, img_rdaddr,
             dpath_wren, dpath_rotation_offset, dpath_result_wraddr
   );

   modport slave (
      output start, last_val,
      input  busy, done, img_rden, img_rdaddr,
             dpath_wren, dpath_rotation_offset, dpath_result_wraddr
   );
`endif
endinterface

// File: rtl/conv_bram_sr_fast_reader.sv
// Read sequencer for the fast shift-register convolution: FILTER_L parallel bank reads per column,
// datapath controls delayed by RD_LATENCY. Optional issue stall via CONV_READER_STALL_EN.
module conv_bram_sr_fast_reader #(
   parameter int DATA_WIDTH = 12,
   parameter int IMG_W      = 16,
   parameter int IMG_H      = 16,
   parameter int IMG_D      = 32,
   parameter int FILTER_L   = 3,
   parameter int RD_LATENCY = 1
) (
   input logic                        clk,
   input logic                        reset,
   conv_bram_sr_fast_reader_if.master bus
);
   localparam int RESULT_W = (IMG_W - FILTER_L) + 1;
   localparam int RESULT_H = (IMG_H - FILTER_L) + 1;
   localparam int AW       = $clog2(IMG_W * IMG_H);
   localparam int FW       = (FILTER_L > 1) ? $clog2(FILTER_L) : 1;
   localparam int RW       = (RESULT_W * RESULT_H > 1) ? $clog2(RESULT_W * RESULT_H) : 1;
   localparam int COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int TOP_W    = (RESULT_H > 1) ? $clog2(RESULT_H) : 1;

   if (RD_LATENCY < 1 || FILTER_L < 1 || FILTER_L > IMG_W || FILTER_L > IMG_H ||
       DATA_WIDTH < 1 || IMG_D < 1) begin : g_bad_cfg
      $error("conv_bram_sr_fast_reader: invalid parameter set");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                   state, next_state;
   logic [COL_W-1:0]         col;
   logic [TOP_W-1:0]         top;
   logic [FW-1:0]            rot;
   logic [RW-1:0]            row_base;
   logic                     stall_now;
   logic                     advance;
   logic                     col_last, top_last, rot_last;
   logic                     issue_last;
   logic [RW-1:0]            tag;
   logic [FILTER_L*AW-1:0]   rd_addr;
   logic [RD_LATENCY-1:0]    wren_pipe;
   logic [RD_LATENCY-1:0][FW-1:0] rot_pipe;
   logic [RD_LATENCY-1:0][RW-1:0] wraddr_pipe;

`ifdef CONV_READER_STALL_EN
   assign stall_now = bus.stall;
`else
   assign stall_now = 1'b0;
`endif

   assign advance    = (state == ISSUE) && !stall_now;
   assign col_last   = (col == COL_W'(IMG_W - 1));
   assign top_last   = (top == TOP_W'(RESULT_H - 1));
   assign rot_last   = (rot == FW'(FILTER_L - 1));
   assign issue_last = advance && col_last && top_last;

   // State register; reset discards any pass in progress.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; start only matters in IDLE and last_val only in DRAIN.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.start) next_state = ISSUE;
         ISSUE:   if (issue_last) next_state = DRAIN;
         DRAIN:   if (bus.last_val) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Column walk across each window; rot and the result row base track top incrementally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col      <= '0;
         top      <= '0;
         rot      <= '0;
         row_base <= '0;
      end else if (state == IDLE && bus.start) begin
         col      <= '0;
         top      <= '0;
         rot      <= '0;
         row_base <= '0;
      end else if (advance) begin
         if (col_last) begin
            col <= '0;
            if (top_last) begin
               top      <= '0;
               rot      <= '0;
               row_base <= '0;
            end else begin
               top      <= top + 1'b1;
               rot      <= rot_last ? '0 : rot + 1'b1;
               row_base <= row_base + RW'(RESULT_W);
            end
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   // Bank j holds row top+((j-rot) mod FILTER_L) of the current window.
   always_comb begin : addr_gen
      int row;
      row     = 0;
      rd_addr = '0;
      for (int j = 0; j < FILTER_L; j++) begin
         if (j >= int'(rot)) row = int'(top) + j - int'(rot);
         else                row = int'(top) + j + FILTER_L - int'(rot);
         if (advance) rd_addr[j*AW +: AW] = AW'(int'(col) + row * IMG_W);
      end
   end

   // The first FILTER_L-1 shifts of a window only prime the shift register.
   assign tag = (col < COL_W'(FILTER_L - 1)) ? row_base
                                               : row_base + RW'(col) - RW'(FILTER_L - 1);

   // Delay line keeps running in every state so in-flight reads always land.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wren_pipe   <= '0;
         rot_pipe    <= '0;
         wraddr_pipe <= '0;
      end else begin
         wren_pipe[0]   <= advance;
         rot_pipe[0]    <= rot;
         wraddr_pipe[0] <= tag;
         for (int i = RD_LATENCY - 1; i > 0; i--) begin
            wren_pipe[i]   <= wren_pipe[i-1];
            rot_pipe[i]    <= rot_pipe[i-1];
            wraddr_pipe[i] <= wraddr_pipe[i-1];
         end
      end
   end

   assign bus.busy                  = (state == ISSUE) || (state == DRAIN);
   assign bus.done                  = (state == DONE);
   assign bus.img_rden              = advance;
   assign bus.img_rdaddr            = rd_addr;
   assign bus.dpath_wren            = wren_pipe[RD_LATENCY-1];
   assign bus.dpath_rotation_offset = rot_pipe[RD_LATENCY-1];
   assign bus.dpath_result_wraddr   = wraddr_pipe[RD_LATENCY-1];
endmodule

// File: tb/tb_conv_bram_sr_fast_reader.sv
// Directed bench for conv_bram_sr_fast_reader on a 5x5 image, 3x3 filter, RD_LATENCY=1.
// Stall scenario is exercised when CONV_READER_STALL_EN is defined.
module tb_conv_bram_sr_fast_reader;
   localparam int W  = 5;
   localparam int H  = 5;
   localparam int L  = 3;
   localparam int RW = W - L + 1;
   localparam int AW = 5;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   int   hi_count;

   conv_bram_sr_fast_reader_if #(.IMG_W(W), .IMG_H(H), .FILTER_L(L)) bus ();

   conv_bram_sr_fast_reader #(
      .DATA_WIDTH(12), .IMG_W(W), .IMG_H(H), .IMG_D(32), .FILTER_L(L), .RD_LATENCY(1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent reference: row order from top mod L, result column minus priming shifts.
   function automatic int exp_addr(int j, int col, int top);
      return col + (top + ((j - (top % L) + L) % L)) * W;
   endfunction

   function automatic int exp_tag(int col, int top);
      return (col < L - 1) ? top * RW : (col - (L - 1)) + top * RW;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic lv);
      bus.start    = s;
      bus.last_val = lv;
      @(posedge clk);
      #1;
   endtask

   task automatic checkBanks(input string tag, input int col, input int top);
      for (int j = 0; j < L; j++)
         checkOutput(tag, 64'(bus.img_rdaddr[j*AW +: AW]), 64'(exp_addr(j, col, top)));
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.last_val = 1'b0;
`ifdef CONV_READER_STALL_EN
      bus.stall    = 1'b0;
`endif
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy",   64'(bus.busy), 0);
      checkOutput("rst_done",   64'(bus.done), 0);
      checkOutput("rst_rden",   64'(bus.img_rden), 0);
      checkOutput("rst_addr",   64'(bus.img_rdaddr), 0);
      checkOutput("rst_wren",   64'(bus.dpath_wren), 0);
      checkOutput("rst_rot",    64'(bus.dpath_rotation_offset), 0);
      checkOutput("rst_wraddr", 64'(bus.dpath_result_wraddr), 0);
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("idle_busy", 64'(bus.busy), 0);

      // Full pass: 15 issue cycles, addresses, rotation and tagged result addresses.
      applyStimulus(1'b1, 1'b0);
      for (int k = 0; k < W * RW; k++) begin
         checkOutput("iss_rden", 64'(bus.img_rden), 1);
         checkOutput("iss_busy", 64'(bus.busy), 1);
         checkBanks("iss_addr", k % W, k / W);
         if (k == 0) begin
            checkOutput("wren_first", 64'(bus.dpath_wren), 0);
         end else begin
            checkOutput("wren", 64'(bus.dpath_wren), 1);
            checkOutput("rot", 64'(bus.dpath_rotation_offset), 64'(((k - 1) / W) % L));
            checkOutput("wraddr", 64'(bus.dpath_result_wraddr),
                        64'(exp_tag((k - 1) % W, (k - 1) / W)));
         end
         applyStimulus(1'b0, 1'b0);
      end
      checkOutput("end_rden",   64'(bus.img_rden), 0);
      checkOutput("end_wren",   64'(bus.dpath_wren), 1);
      checkOutput("end_rot",    64'(bus.dpath_rotation_offset), 2);
      checkOutput("end_wraddr", 64'(bus.dpath_result_wraddr), 8);

      // Drain waits for last_val; start during busy is ignored.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i == 3, 1'b0);
         checkOutput("drain_busy", 64'(bus.busy), 1);
         checkOutput("drain_done", 64'(bus.done), 0);
         checkOutput("drain_rden", 64'(bus.img_rden), 0);
         if (i == 0) checkOutput("drain_wren", 64'(bus.dpath_wren), 0);
      end
      applyStimulus(1'b0, 1'b1);
      checkOutput("done_pulse", 64'(bus.done), 1);
      checkOutput("done_busy",  64'(bus.busy), 0);
      applyStimulus(1'b0, 1'b0);
      checkOutput("done_clear", 64'(bus.done), 0);
      checkOutput("post_busy",  64'(bus.busy), 0);
      checkOutput("post_rden",  64'(bus.img_rden), 0);

      // Reset in the middle of a pass at top=1 col=2.
      applyStimulus(1'b1, 1'b0);
      for (int i = 0; i < W + 2; i++) applyStimulus(1'b0, 1'b0);
      checkBanks("mid_addr", 2, 1);
      checkOutput("mid_rot", 64'(bus.dpath_rotation_offset), 1);
      reset = 1'b0;
      #1;
      checkOutput("arst_busy",   64'(bus.busy), 0);
      checkOutput("arst_done",   64'(bus.done), 0);
      checkOutput("arst_rden",   64'(bus.img_rden), 0);
      checkOutput("arst_addr",   64'(bus.img_rdaddr), 0);
      checkOutput("arst_wren",   64'(bus.dpath_wren), 0);
      checkOutput("arst_rot",    64'(bus.dpath_rotation_offset), 0);
      checkOutput("arst_wraddr", 64'(bus.dpath_result_wraddr), 0);
      #2;
      reset = 1'b1;
      applyStimulus(1'b0, 1'b0);
      checkOutput("rel_busy", 64'(bus.busy), 0);
      applyStimulus(1'b1, 1'b0);
      checkBanks("restart_addr", 0, 0);
      checkOutput("restart_wren", 64'(bus.dpath_wren), 0);

      // Complete the restarted pass; a last_val pulse during issue must not end it.
      hi_count = 1;
      for (int i = 0; i < 100 && bus.img_rden; i++) begin
         applyStimulus(1'b0, i == 0);
         if (bus.img_rden) hi_count++;
      end
      checkOutput("restart_rden_end", 64'(bus.img_rden), 0);
      checkOutput("restart_issues", 64'(hi_count), 15);
      checkOutput("restart_done_early", 64'(bus.done), 0);
      checkOutput("restart_busy", 64'(bus.busy), 1);
      applyStimulus(1'b0, 1'b1);
      checkOutput("restart_done", 64'(bus.done), 1);
      applyStimulus(1'b0, 1'b0);

`ifdef CONV_READER_STALL_EN
      // Three-cycle stall at col=2 leaves a matching hole in dpath_wren.
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0);
      hi_count = 2;
      bus.stall = 1'b1;
      #1;
      checkOutput("stall_rden0", 64'(bus.img_rden), 0);
      checkOutput("stall_wren0", 64'(bus.dpath_wren), 1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 1'b0);
         checkOutput("stall_rden", 64'(bus.img_rden), 0);
         checkOutput("stall_wren", 64'(bus.dpath_wren), 0);
      end
      applyStimulus(1'b0, 1'b0);
      bus.stall = 1'b0;
      #1;
      checkOutput("resume_wren", 64'(bus.dpath_wren), 0);
      checkOutput("resume_rden", 64'(bus.img_rden), 1);
      checkBanks("resume_addr", 2, 0);
      hi_count++;
      applyStimulus(1'b0, 1'b0);
      checkOutput("resume_wren1", 64'(bus.dpath_wren), 1);
      if (bus.img_rden) hi_count++;
      for (int i = 0; i < 100 && bus.img_rden; i++) begin
         applyStimulus(1'b0, 1'b0);
         if (bus.img_rden) hi_count++;
      end
      checkOutput("stall_issues", 64'(hi_count), 15);
      applyStimulus(1'b0, 1'b1);
      checkOutput("stall_done", 64'(bus.done), 1);
      applyStimulus(1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
